// File: rtl/fifo_port_sched_if.sv
// rtl/fifo_port_sched_if.sv - writer, reader and FIFO-side signal bundle for fifo_port_sched
interface fifo_port_sched_if;
    logic       wr0_req;
    logic [7:0] wr0_data;
    logic       wr0_ack;
    logic       wr1_req;
    logic [7:0] wr1_data;
    logic       wr1_ack;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [7:0] fifo_data_in;
    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_data_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic [2:0] fifo_level;
    logic       sync_err;

    // master: the surroundings (writers, reader, FIFO); slave: the scheduler
    modport master (
        output wr0_req, wr0_data, wr1_req, wr1_data, rd_ready,
               fifo_data_out, fifo_empty, fifo_full,
        input  wr0_ack, wr1_ack, rd_valid, rd_data,
               fifo_data_in, fifo_push, fifo_pop, fifo_level, sync_err
    );

    modport slave (
        input  wr0_req, wr0_data, wr1_req, wr1_data, rd_ready,
               fifo_data_out, fifo_empty, fifo_full,
        output wr0_ack, wr1_ack, rd_valid, rd_data,
               fifo_data_in, fifo_push, fifo_pop, fifo_level, sync_err
    );
endinterface

// File: rtl/fifo_port_sched.sv
// rtl/fifo_port_sched.sv - two-writer push arbiter and pop sequencer for the 4-deep UART byte FIFO
module fifo_port_sched #(
    parameter int WR_PRIO    = 0,
    parameter bit PUSH_FIRST = 1'b1,
    parameter int DEPTH      = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    fifo_port_sched_if.slave bus
);
    typedef enum logic {IDLE, STROBE} state_t;

    localparam logic [2:0] LEVEL_MAX = 3'(DEPTH);

    state_t     state, state_d;
    logic       push_q, push_d;
    logic       pop_q, pop_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       rd_valid_q, rd_valid_d;
    logic       sync_err_q, sync_err_d;
    logic       tie_push_q, tie_push_d;
    logic       rr_wr1_q, rr_wr1_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] data_in_q, data_in_d;
    logic [2:0] level_q, level_d;

    logic push_cand, pop_cand, do_push, do_pop, grant_wr1, level_bad;

    assign push_cand = (bus.wr0_req | bus.wr1_req) & ~bus.fifo_full;
    assign pop_cand  = ~rd_valid_q & ~bus.fifo_empty;
    // tie_push_q remembers the last operation: 1 after a pop, so a tie goes to push
    assign do_push   = push_cand & (~pop_cand | tie_push_q);
    assign do_pop    = pop_cand & (~push_cand | ~tie_push_q);
    assign grant_wr1 = (WR_PRIO != 0) ? ~bus.wr0_req
                                      : (bus.wr1_req & (~bus.wr0_req | rr_wr1_q));
    assign level_bad = ((level_q == LEVEL_MAX) != bus.fifo_full) ||
                       ((level_q == 3'd0) != bus.fifo_empty);

    always_comb begin
        state_d    = IDLE;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        data_in_d  = data_in_q;
        level_d    = level_q;
        rd_valid_d = rd_valid_q & ~bus.rd_ready;
        rd_data_d  = rd_data_q;
        sync_err_d = sync_err_q;
        tie_push_d = tie_push_q;
        rr_wr1_d   = rr_wr1_q;
        case (state)
            IDLE: begin
                if (level_bad)
                    sync_err_d = 1'b1;
                if (do_push) begin
                    state_d    = STROBE;
                    push_d     = 1'b1;
                    ack0_d     = ~grant_wr1;
                    ack1_d     = grant_wr1;
                    data_in_d  = grant_wr1 ? bus.wr1_data : bus.wr0_data;
                    tie_push_d = 1'b0;
                    rr_wr1_d   = ~grant_wr1;
                end else if (do_pop) begin
                    state_d    = STROBE;
                    pop_d      = 1'b1;
                    tie_push_d = 1'b1;
                end
            end
            STROBE: begin
                // FIFO moves its indices at this same edge; head byte is still valid now
                if (push_q)
                    level_d = level_q + 3'd1;
                if (pop_q) begin
                    level_d    = level_q - 3'd1;
                    rd_data_d  = bus.fifo_data_out;
                    rd_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            sync_err_q <= 1'b0;
            tie_push_q <= PUSH_FIRST;
            rr_wr1_q   <= 1'b0;
            rd_data_q  <= 8'h00;
            data_in_q  <= 8'h00;
            level_q    <= 3'd0;
        end else begin
            state      <= state_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rd_valid_q <= rd_valid_d;
            sync_err_q <= sync_err_d;
            tie_push_q <= tie_push_d;
            rr_wr1_q   <= rr_wr1_d;
            rd_data_q  <= rd_data_d;
            data_in_q  <= data_in_d;
            level_q    <= level_d;
        end
    end

    assign bus.wr0_ack      = ack0_q;
    assign bus.wr1_ack      = ack1_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.fifo_data_in = data_in_q;
    assign bus.fifo_push    = push_q;
    assign bus.fifo_pop     = pop_q;
    assign bus.fifo_level   = level_q;
    assign bus.sync_err     = sync_err_q;
endmodule

// File: tb/tb_fifo_port_sched.sv
// tb/tb_fifo_port_sched.sv - directed bench for fifo_port_sched with behavioural 4-deep edge-triggered FIFOs
module tb_fifo_port_sched;
    logic clk;
    logic reset_n;

    fifo_port_sched_if a ();
    fifo_port_sched_if b ();

    fifo_port_sched #(.WR_PRIO(0)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a.slave));
    fifo_port_sched #(.WR_PRIO(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO models: act on rising edge of push/pop, push wins
    logic [7:0] mem_a [4];
    logic [1:0] wp_a, rp_a;
    logic [2:0] cnt_a;
    logic       push_dq_a, pop_dq_a;
    always @(posedge clk) begin
        if (!reset_n) begin
            wp_a <= 2'd0; rp_a <= 2'd0; cnt_a <= 3'd0; push_dq_a <= 1'b0; pop_dq_a <= 1'b0;
        end else begin
            push_dq_a <= a.fifo_push;
            pop_dq_a  <= a.fifo_pop;
            if (a.fifo_push && !push_dq_a && cnt_a < 3'd4) begin
                mem_a[wp_a] <= a.fifo_data_in;
                wp_a <= wp_a + 2'd1;
                cnt_a <= cnt_a + 3'd1;
            end else if (a.fifo_pop && !pop_dq_a && cnt_a > 3'd0) begin
                rp_a <= rp_a + 2'd1;
                cnt_a <= cnt_a - 3'd1;
            end
        end
    end
    assign a.fifo_data_out = mem_a[rp_a];
    assign a.fifo_empty    = (cnt_a == 3'd0);
    assign a.fifo_full     = (cnt_a == 3'd4);

    logic [7:0] mem_b [4];
    logic [1:0] wp_b, rp_b;
    logic [2:0] cnt_b;
    logic       push_dq_b, pop_dq_b;
    always @(posedge clk) begin
        if (!reset_n) begin
            wp_b <= 2'd0; rp_b <= 2'd0; cnt_b <= 3'd0; push_dq_b <= 1'b0; pop_dq_b <= 1'b0;
        end else begin
            push_dq_b <= b.fifo_push;
            pop_dq_b  <= b.fifo_pop;
            if (b.fifo_push && !push_dq_b && cnt_b < 3'd4) begin
                mem_b[wp_b] <= b.fifo_data_in;
                wp_b <= wp_b + 2'd1;
                cnt_b <= cnt_b + 3'd1;
            end else if (b.fifo_pop && !pop_dq_b && cnt_b > 3'd0) begin
                rp_b <= rp_b + 2'd1;
                cnt_b <= cnt_b - 3'd1;
            end
        end
    end
    assign b.fifo_data_out = mem_b[rp_b];
    assign b.fifo_empty    = (cnt_b == 3'd0);
    assign b.fifo_full     = (cnt_b == 3'd4);

    int          n_checks = 0;
    int          n_pass   = 0;
    int          viol     = 0;
    int          n_ops    = 0;
    int          b_ack0   = 0;
    int          b_ack1   = 0;
    logic [31:0] op_sig   = 32'h0;
    logic        prev_strobe = 1'b0;
    logic        auto_inc = 1'b0;
    logic [7:0]  out_q [$];
    logic        seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // one clock: log pending output transfer, then sample at the falling edge
    task automatic tick();
        if (a.rd_valid && a.rd_ready)
            out_q.push_back(a.rd_data);
        @(negedge clk);
        if (a.fifo_push && a.fifo_pop) viol++;
        if ((a.fifo_push || a.fifo_pop) && prev_strobe) viol++;
        prev_strobe = a.fifo_push || a.fifo_pop;
        if (a.fifo_push) begin
            n_ops++;
            op_sig = {op_sig[27:0], a.wr0_ack ? 4'h1 : (a.wr1_ack ? 4'h2 : 4'hF)};
            if (cnt_a == 3'd4) viol++;
        end
        if (a.fifo_pop) begin
            n_ops++;
            op_sig = {op_sig[27:0], 4'h3};
            if (cnt_a == 3'd0) viol++;
        end
        if (auto_inc) begin
            if (a.wr0_ack) a.wr0_data = a.wr0_data + 8'd1;
            if (a.wr1_ack) a.wr1_data = a.wr1_data + 8'd1;
        end
        if (b.wr0_ack) b_ack0++;
        if (b.wr1_ack) b_ack1++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_strobes"}, {26'd0, a.fifo_push, a.fifo_pop, a.wr0_ack, a.wr1_ack, a.rd_valid, a.sync_err}, 32'h0);
        check({tag, "_level"}, {29'd0, a.fifo_level}, 32'h0);
        check({tag, "_rd_data"}, {24'd0, a.rd_data}, 32'h0);
        check({tag, "_data_in"}, {24'd0, a.fifo_data_in}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        a.wr0_req = 1'b0; a.wr0_data = 8'h00; a.wr1_req = 1'b0; a.wr1_data = 8'h00; a.rd_ready = 1'b0;
        b.wr0_req = 1'b0; b.wr0_data = 8'h00; b.wr1_req = 1'b0; b.wr1_data = 8'h00; b.rd_ready = 1'b0;
        ticks(3);
        check_zero_outputs("rst");
        reset_n = 1'b1;
        n_ops = 0;
        ticks(20);
        check("idle_no_ops", n_ops, 0);

        // single round trip
        a.wr0_req = 1'b1; a.wr0_data = 8'hA5;
        tick();
        check("rt_push_ack", {30'd0, a.fifo_push, a.wr0_ack}, 32'h3);
        check("rt_data_in", {24'd0, a.fifo_data_in}, 32'hA5);
        a.wr0_req = 1'b0;
        tick();
        check("rt_idle_gap", {30'd0, a.fifo_push, a.fifo_pop}, 32'h0);
        check("rt_level1", {29'd0, a.fifo_level}, 32'd1);
        tick();
        check("rt_pop", {30'd0, a.fifo_push, a.fifo_pop}, 32'h1);
        tick();
        check("rt_rd_valid", {31'd0, a.rd_valid}, 32'd1);
        check("rt_rd_data", {24'd0, a.rd_data}, 32'hA5);
        check("rt_level0", {29'd0, a.fifo_level}, 32'd0);
        a.rd_ready = 1'b1;
        tick();
        check("rt_consumed", {31'd0, a.rd_valid}, 32'd0);
        a.rd_ready = 1'b0;

        // fresh arbiter state, two continuous writers, no consumer
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        n_ops = 0; op_sig = 32'h0; viol = 0;
        a.wr0_req = 1'b1; a.wr0_data = 8'h10;
        a.wr1_req = 1'b1; a.wr1_data = 8'h20;
        auto_inc = 1'b1;
        ticks(16);
        check("fill_n_ops", n_ops, 6);
        check("fill_order", op_sig, 32'h00132121);
        check("fill_level", {29'd0, a.fifo_level}, 32'd4);
        check("fill_fifo_full", {31'd0, a.fifo_full}, 32'd1);
        check("fill_rd_data", {24'd0, a.rd_data}, 32'h10);
        check("fill_wr1_stalled", {24'd0, a.wr1_data}, 32'h22);
        check("fill_wr0_next", {24'd0, a.wr0_data}, 32'h13);

        // consumer always ready: alternating pop/push, bytes in push order
        out_q.delete();
        a.rd_ready = 1'b1;
        ticks(48);
        check("drain_count_ge8", {31'd0, out_q.size() >= 8}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < out_q.size())
                check($sformatf("drain_byte%0d", i), {24'd0, out_q[i]},
                      (i % 2 == 0) ? 32'h10 + i / 2 : 32'h20 + i / 2);
        end
        check("drain_violations", viol, 0);
        check("drain_sync_err", {31'd0, a.sync_err}, 32'd0);

        // fixed priority instance: wr0 hogs the port while it requests
        b.wr0_req = 1'b1; b.wr0_data = 8'h33;
        b.wr1_req = 1'b1; b.wr1_data = 8'h44;
        b.rd_ready = 1'b1;
        b_ack0 = 0; b_ack1 = 0;
        ticks(30);
        check("prio_wr1_no_ack", b_ack1, 0);
        check("prio_wr0_acks", {31'd0, b_ack0 >= 5}, 32'd1);
        b.wr0_req = 1'b0;
        ticks(10);
        check("prio_wr1_after", {31'd0, b_ack1 != 0}, 32'd1);
        b.wr1_req = 1'b0;

        // reset in the middle of a push strobe
        a.wr0_req = 1'b0; a.wr1_req = 1'b0; auto_inc = 1'b0;
        ticks(24);
        check("pre_rst_drained", {29'd0, a.fifo_level}, 32'd0);
        a.rd_ready = 1'b0;
        a.wr0_req = 1'b1; a.wr0_data = 8'h77;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = a.fifo_push;
        end
        check("mid_push_seen", {31'd0, seen}, 32'd1);
        reset_n = 1'b0;
        a.wr0_req = 1'b0;
        tick();
        check_zero_outputs("mid_rst");
        check("mid_rst_fifo_cnt", {29'd0, cnt_a}, 32'd0);
        reset_n = 1'b1;
        a.wr0_req = 1'b1; a.wr0_data = 8'h5A;
        tick();
        check("post_push_ack", {30'd0, a.fifo_push, a.wr0_ack}, 32'h3);
        a.wr0_req = 1'b0;
        ticks(3);
        check("post_rd_valid", {31'd0, a.rd_valid}, 32'd1);
        check("post_rd_data", {24'd0, a.rd_data}, 32'h5A);
        check("post_level", {29'd0, a.fifo_level}, 32'd0);
        check("post_sync_err", {31'd0, a.sync_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
